alu_exec_unit: RTL

- Execution-side consumer of the 5-bit ALUCtl / Sign control pair produced by the ALU control decoder.
- Performs the selected operation on two 32-bit operands.
- Shifts are iterative, one bit position per cycle; all other ops complete in one cycle.
- Sits between operand fetch and writeback in the multi-cycle datapath, with valid/ready handshakes on both sides.

---
 rtl/alu_exec_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Iterative-shift ALU execution unit with valid/ready handshakes on both sides.
// Optional signed-overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUCtl,
    input  logic             Sign,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01100;
    localparam logic [4:0] OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SLL = 5'b10000;
    localparam logic [4:0] OP_SRL = 5'b11000;
    localparam logic [4:0] OP_SRA = 5'b11001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   shreg, shreg_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [4:0]         op_q, op_next;
    logic [WIDTH-1:0]   result_next;
    logic [WIDTH-1:0]   sum_c, diff_c, alu_res_c, shift_step_c;
    logic               slt_c, is_shift_c;
    logic               ovf_next, ovf_c;

    assign sum_c      = in_a + in_b;
    assign diff_c     = in_a - in_b;
    assign slt_c      = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
    assign is_shift_c = (ALUCtl == OP_SLL) || (ALUCtl == OP_SRL) || (ALUCtl == OP_SRA);

    // Single-cycle operations; unlisted codes fall back to ADD
    always_comb begin
        alu_res_c = sum_c;
        case (ALUCtl)
            OP_AND:  alu_res_c = in_a & in_b;
            OP_OR:   alu_res_c = in_a | in_b;
            OP_ADD:  alu_res_c = sum_c;
            OP_SUB:  alu_res_c = diff_c;
            OP_SLT:  alu_res_c = {{(WIDTH-1){1'b0}}, slt_c};
            OP_NOR:  alu_res_c = ~(in_a | in_b);
            OP_XOR:  alu_res_c = in_a ^ in_b;
            default: alu_res_c = sum_c;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        ovf_c = 1'b0;
        if (Sign) begin
            if (ALUCtl == OP_ADD)
                ovf_c = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_c[WIDTH-1] != in_a[WIDTH-1]);
            else if (ALUCtl == OP_SUB)
                ovf_c = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff_c[WIDTH-1] != in_a[WIDTH-1]);
        end
    end
`else
    assign ovf_c = 1'b0;
`endif

    // One bit position per cycle for the latched shift op
    always_comb begin
        shift_step_c = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
        case (op_q)
            OP_SLL:  shift_step_c = {shreg[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_step_c = {1'b0, shreg[WIDTH-1:1]};
            default: shift_step_c = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
        endcase
    end

    // Next-state and datapath next values
    always_comb begin
        state_next  = state;
        shreg_next  = shreg;
        cnt_next    = cnt;
        op_next     = op_q;
        result_next = result;
`ifdef ALU_OVERFLOW_EN
        ovf_next    = overflow;
`else
        ovf_next    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift_c) begin
                        shreg_next = in_b;
                        cnt_next   = in_a[CNT_W-1:0];
                        op_next    = ALUCtl;
                        ovf_next   = 1'b0;
                        if (in_a[CNT_W-1:0] == '0) begin
                            result_next = in_b;
                            state_next  = DONE;
                        end else begin
                            state_next  = SHIFT;
                        end
                    end else begin
                        result_next = alu_res_c;
                        ovf_next    = ovf_c;
                        state_next  = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_next = shift_step_c;
                cnt_next   = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    result_next = shift_step_c;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            op_q      <= '0;
            result    <= '0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            cnt       <= cnt_next;
            op_q      <= op_next;
            result    <= result_next;
            zero      <= (result_next == '0);
            out_valid <= (state_next == DONE);
            in_ready  <= (state_next == IDLE);
        end
    end

`ifdef ALU_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else
            overflow <= ovf_next;
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf_next ^ ovf_c;
`endif

endmodule
